// File: rtl/iq_demod_pkg.sv
// Shared signed sample, product and accumulator types for the IQ demodulator.
// Also holds the 16-bit saturation bounds at accumulator width.
package iq_demod_pkg;

    typedef logic signed [15:0] ws16_t;
    typedef logic signed [31:0] ws32_t;
    typedef logic signed [47:0] ws48_t;

    localparam ws48_t WS16_MAX = 48'sd32767;
    localparam ws48_t WS16_MIN = -48'sd32768;

endpackage

// File: rtl/iq_demod_sat.sv
// IQ_SAT: combinational arithmetic right shift of a 48-bit block sum down to 16 bits.
// Results outside the 16-bit range saturate and raise o_sat.
module iq_sat
    import iq_demod_pkg::*;
#(
    parameter int unsigned SHIFT = 6
) (
    input  ws48_t i_sum,
    output ws16_t o_y,
    output logic  o_sat
);

    ws48_t w_shr;

    always_comb begin
        w_shr = i_sum >>> (15 + SHIFT);
        o_y   = w_shr[15:0];
        o_sat = 1'b0;
        if (w_shr > WS16_MAX) begin
            o_y   = 16'sh7fff;
            o_sat = 1'b1;
        end else if (w_shr < WS16_MIN) begin
            o_y   = 16'sh8000;
            o_sat = 1'b1;
        end
    end

endmodule

// File: rtl/iq_demod.sv
// IQ integrate-and-dump demodulator: mix input with the LO, sum DEC_LEN products,
// then shift and saturate each block sum to 16 bits, with a sticky overflow flag.
module iq_demod
    import iq_demod_pkg::*;
#(
    parameter int unsigned DEC_LEN = 64,
    parameter int unsigned SHIFT   = 6
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  in_valid,
    input  ws16_t in_data,
    input  ws16_t cos,
    input  ws16_t sin,
    output logic  out_valid,
    output ws16_t i_out,
    output ws16_t q_out,
    output logic  ovf
);

    localparam int unsigned CW   = (DEC_LEN > 1) ? $clog2(DEC_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEC_LEN - 1);

    logic          r_v1;
    ws32_t         r_pi;
    ws32_t         r_pq;
    ws48_t         r_acc_i;
    ws48_t         r_acc_q;
    logic [CW-1:0] r_cnt;
    logic          r_dump;
    ws48_t         r_sum_i;
    ws48_t         r_sum_q;

    ws32_t w_pi;
    ws32_t w_pq;
    ws48_t w_sum_i;
    ws48_t w_sum_q;
    ws16_t w_i;
    ws16_t w_q;
    logic  w_sat_i;
    logic  w_sat_q;

    assign w_pi    = ws32_t'(in_data) * ws32_t'(cos);
    assign w_pq    = -(ws32_t'(in_data) * ws32_t'(sin));
    assign w_sum_i = r_acc_i + ws48_t'(r_pi);
    assign w_sum_q = r_acc_q + ws48_t'(r_pq);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1 <= 1'b0;
            r_pi <= '0;
            r_pq <= '0;
        end else if (clr) begin
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_pi <= w_pi;
                r_pq <= w_pq;
            end
        end
    end

    // The final product of a block goes straight into the dump sum, so the next block starts from zero without a dead cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc_i <= '0;
            r_acc_q <= '0;
            r_cnt   <= '0;
            r_dump  <= 1'b0;
            r_sum_i <= '0;
            r_sum_q <= '0;
        end else if (clr) begin
            r_acc_i <= '0;
            r_acc_q <= '0;
            r_cnt   <= '0;
            r_dump  <= 1'b0;
        end else begin
            r_dump <= 1'b0;
            if (r_v1) begin
                if (r_cnt == LAST) begin
                    r_sum_i <= w_sum_i;
                    r_sum_q <= w_sum_q;
                    r_acc_i <= '0;
                    r_acc_q <= '0;
                    r_cnt   <= '0;
                    r_dump  <= 1'b1;
                end else begin
                    r_acc_i <= w_sum_i;
                    r_acc_q <= w_sum_q;
                    r_cnt   <= r_cnt + CW'(1);
                end
            end
        end
    end

    iq_sat #(.SHIFT(SHIFT)) u_sat_i (
        .i_sum (r_sum_i),
        .o_y   (w_i),
        .o_sat (w_sat_i)
    );

    iq_sat #(.SHIFT(SHIFT)) u_sat_q (
        .i_sum (r_sum_q),
        .o_y   (w_q),
        .o_sat (w_sat_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            i_out     <= '0;
            q_out     <= '0;
            ovf       <= 1'b0;
        end else if (clr) begin
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= r_dump;
            if (r_dump) begin
                i_out <= w_i;
                q_out <= w_q;
                if (w_sat_i || w_sat_q)
                    ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iq_demod.sv
// Self-checking bench for iq_demod: directed scenarios plus a randomized run
// compared against a block-sum model computed with plain integer arithmetic.
module tb_iq_demod;

    localparam int DEC = 64;
    localparam int SH  = 6;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clr = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [15:0] in_data = '0;
    logic signed [15:0] lo_cos = '0;
    logic signed [15:0] lo_sin = '0;
    logic               out_valid;
    logic signed [15:0] i_out;
    logic signed [15:0] q_out;
    logic               ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int                 pq_cyc[$];
    logic signed [15:0] pq_i[$];
    logic signed [15:0] pq_q[$];

    iq_demod #(.DEC_LEN(DEC), .SHIFT(SH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .cos       (lo_cos),
        .sin       (lo_sin),
        .out_valid (out_valid),
        .i_out     (i_out),
        .q_out     (q_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            pq_cyc.push_back(cyc);
            pq_i.push_back(i_out);
            pq_q.push_back(q_out);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference: floor(sum / 2^(15+SH)) clamped to 16 bits.
    task automatic model_scale(input longint sum, output logic signed [15:0] y, output bit sat);
        longint d;
        longint q;
        d = longint'(1) << (15 + SH);
        if (sum >= 0) q = sum / d;
        else          q = -((-sum + d - 1) / d);
        sat = 1'b0;
        if (q > 32767)       begin y = 16'sh7fff; sat = 1'b1; end
        else if (q < -32768) begin y = 16'sh8000; sat = 1'b1; end
        else                 y = 16'(q);
    endtask

    task automatic send(input logic v, input logic signed [15:0] d, input logic signed [15:0] c,
                        input logic signed [15:0] s);
        in_valid = v;
        in_data  = d;
        lo_cos   = c;
        lo_sin   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic do_clr();
        clr = 1'b1;
        send(1'b1, 16'sd16384, 16'sd32767, 16'sd0);
        clr = 1'b0;
    endtask

    task automatic send_block(input logic signed [15:0] d, input logic signed [15:0] c,
                              input logic signed [15:0] s, input bit alt, output int t_last);
        for (int i = 0; i < DEC; i++) begin
            if (alt && i > 0) idle(1);
            send(1'b1, d, c, s);
        end
        t_last = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (i_out !== 16'sd0)   begin errors++; $display("FAIL reset_i_out: got %0d expected 0", i_out); end
        checks++; if (q_out !== 16'sd0)   begin errors++; $display("FAIL reset_q_out: got %0d expected 0", q_out); end
        checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL reset_ovf: got %0b expected 0", ovf); end
        rst = 1'b1;
        idle(2);
    endtask

    task automatic test_cos_block();
        int t;
        pq_cyc.delete(); pq_i.delete(); pq_q.delete();
        send_block(16'sd16384, 16'sd32767, 16'sd0, 1'b0, t);
        idle(4);
        checks++; if (pq_cyc.size() != 1) begin errors++; $display("FAIL cos_pulses: got %0d expected 1", pq_cyc.size()); end
        else begin
            checks++; if (pq_cyc[0] != t + 2) begin errors++; $display("FAIL cos_latency: got cycle %0d expected %0d", pq_cyc[0], t + 2); end
            checks++; if (pq_i[0] !== 16'sd16383) begin errors++; $display("FAIL cos_i_out: got %0d expected 16383", pq_i[0]); end
            checks++; if (pq_q[0] !== 16'sd0) begin errors++; $display("FAIL cos_q_out: got %0d expected 0", pq_q[0]); end
        end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL cos_ovf: got %0b expected 0", ovf); end
        checks++; if (i_out !== 16'sd16383) begin errors++; $display("FAIL cos_i_hold: got %0d expected 16383", i_out); end
    endtask

    task automatic test_sin_block();
        int t;
        pq_cyc.delete(); pq_i.delete(); pq_q.delete();
        send_block(16'sd16384, 16'sd0, 16'sd16384, 1'b0, t);
        idle(4);
        checks++; if (pq_cyc.size() != 1) begin errors++; $display("FAIL sin_pulses: got %0d expected 1", pq_cyc.size()); end
        else begin
            checks++; if (pq_i[0] !== 16'sd0) begin errors++; $display("FAIL sin_i_out: got %0d expected 0", pq_i[0]); end
            checks++; if (pq_q[0] !== -16'sd8192) begin errors++; $display("FAIL sin_q_out: got %0d expected -8192", pq_q[0]); end
        end
    endtask

    task automatic test_ovf();
        int t;
        pq_cyc.delete(); pq_i.delete(); pq_q.delete();
        send_block(-16'sd32768, -16'sd32768, 16'sd0, 1'b0, t);
        idle(4);
        checks++; if (pq_i.size() != 1 || pq_i[0] !== 16'sd32767) begin errors++; $display("FAIL ovf_i_sat: got %0d expected 32767", i_out); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b expected 1", ovf); end
        send_block(16'sd16384, 16'sd32767, 16'sd0, 1'b0, t);
        idle(4);
        checks++; if (i_out !== 16'sd16383) begin errors++; $display("FAIL ovf_next_i: got %0d expected 16383", i_out); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b expected 1", ovf); end
        do_clr();
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %0b expected 0", ovf); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_out_valid: got %0b expected 0", out_valid); end
        checks++; if (i_out !== 16'sd16383) begin errors++; $display("FAIL clr_i_hold: got %0d expected 16383", i_out); end
    endtask

    task automatic test_clear();
        int t;
        pq_cyc.delete(); pq_i.delete(); pq_q.delete();
        // Partial block followed by clr (with a valid sample) must be forgotten.
        for (int i = 0; i < 10; i++) send(1'b1, -16'sd20000, 16'sd30000, 16'sd12345);
        do_clr();
        send_block(16'sd16384, 16'sd32767, 16'sd0, 1'b0, t);
        idle(4);
        checks++; if (pq_cyc.size() != 1) begin errors++; $display("FAIL clr_mid_pulses: got %0d expected 1", pq_cyc.size()); end
        else begin
            checks++; if (pq_cyc[0] != t + 2) begin errors++; $display("FAIL clr_mid_latency: got %0d expected %0d", pq_cyc[0], t + 2); end
            checks++; if (pq_i[0] !== 16'sd16383 || pq_q[0] !== 16'sd0) begin errors++; $display("FAIL clr_mid_value: got %0d/%0d expected 16383/0", pq_i[0], pq_q[0]); end
        end
        // clr right after the closing sample discards the in-flight dump.
        pq_cyc.delete(); pq_i.delete(); pq_q.delete();
        for (int i = 0; i < DEC; i++) send(1'b1, 16'sd1000, 16'sd1000, 16'sd0);
        do_clr();
        idle(4);
        checks++; if (pq_cyc.size() != 0) begin errors++; $display("FAIL clr_inflight: got %0d pulses expected 0", pq_cyc.size()); end
        checks++; if (i_out !== 16'sd16383) begin errors++; $display("FAIL clr_inflight_hold: got %0d expected 16383", i_out); end
    endtask

    task automatic test_gaps();
        int t;
        int t0;
        pq_cyc.delete(); pq_i.delete(); pq_q.delete();
        t0 = cyc;
        send_block(16'sd16384, 16'sd32767, 16'sd0, 1'b1, t);
        idle(4);
        checks++; if (t - t0 != 2 * DEC - 1) begin errors++; $display("FAIL gap_span: got %0d cycles expected %0d", t - t0, 2 * DEC - 1); end
        checks++; if (pq_cyc.size() != 1) begin errors++; $display("FAIL gap_pulses: got %0d expected 1", pq_cyc.size()); end
        else begin
            checks++; if (pq_cyc[0] != t + 2) begin errors++; $display("FAIL gap_latency: got %0d expected %0d", pq_cyc[0], t + 2); end
            checks++; if (pq_i[0] !== 16'sd16383 || pq_q[0] !== 16'sd0) begin errors++; $display("FAIL gap_value: got %0d/%0d expected 16383/0", pq_i[0], pq_q[0]); end
        end
    endtask

    task automatic test_rst_mid();
        int t;
        for (int i = 0; i < 30; i++) send(1'b1, 16'sd16384, 16'sd32767, 16'sd0);
        rst = 1'b0;
        #2;
        checks++; if (i_out !== 16'sd0 || q_out !== 16'sd0) begin errors++; $display("FAIL rst_mid_out: got %0d/%0d expected 0/0", i_out, q_out); end
        checks++; if (out_valid !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: got %0b/%0b expected 0/0", out_valid, ovf); end
        @(posedge clk);
        #1 rst = 1'b1;
        pq_cyc.delete(); pq_i.delete(); pq_q.delete();
        for (int i = 0; i < DEC - 1; i++) send(1'b1, 16'sd16384, 16'sd32767, 16'sd0);
        idle(3);
        checks++; if (pq_cyc.size() != 0) begin errors++; $display("FAIL rst_mid_early: got %0d pulses expected 0", pq_cyc.size()); end
        send(1'b1, 16'sd16384, 16'sd32767, 16'sd0);
        t = cyc;
        idle(4);
        checks++; if (pq_cyc.size() != 1) begin errors++; $display("FAIL rst_mid_pulses: got %0d expected 1", pq_cyc.size()); end
        else begin
            checks++; if (pq_cyc[0] != t + 2 || pq_i[0] !== 16'sd16383) begin errors++; $display("FAIL rst_mid_value: got %0d at %0d expected 16383 at %0d", pq_i[0], pq_cyc[0], t + 2); end
        end
    endtask

    task automatic test_back_to_back();
        int t;
        pq_cyc.delete(); pq_i.delete(); pq_q.delete();
        for (int b = 0; b < 3; b++) send_block(16'sd16384, 16'sd32767, 16'sd0, 1'b0, t);
        idle(4);
        checks++; if (pq_cyc.size() != 3) begin errors++; $display("FAIL b2b_pulses: got %0d expected 3", pq_cyc.size()); end
        else begin
            checks++; if (pq_cyc[2] != t + 2) begin errors++; $display("FAIL b2b_last: got %0d expected %0d", pq_cyc[2], t + 2); end
            for (int k = 0; k < 3; k++) begin
                checks++; if (pq_i[k] !== 16'sd16383) begin errors++; $display("FAIL b2b_i_%0d: got %0d expected 16383", k, pq_i[k]); end
                if (k > 0) begin
                    checks++; if (pq_cyc[k] - pq_cyc[k-1] != DEC) begin errors++; $display("FAIL b2b_spacing_%0d: got %0d expected %0d", k, pq_cyc[k] - pq_cyc[k-1], DEC); end
                end
            end
        end
    endtask

    task automatic test_random();
        longint             si;
        longint             sq;
        int                 n;
        int                 blocks;
        bit                 ovf_m;
        bit                 s1;
        bit                 s2;
        logic signed [15:0] ei;
        logic signed [15:0] eq;
        logic signed [15:0] d;
        logic signed [15:0] c;
        logic signed [15:0] s;
        logic               v;
        int                 e_cyc[$];
        logic signed [15:0] e_i[$];
        logic signed [15:0] e_q[$];
        do_clr();
        pq_cyc.delete(); pq_i.delete(); pq_q.delete();
        si = 0; sq = 0; n = 0; blocks = 0; ovf_m = 1'b0;
        for (int it = 0; it < 2000 && blocks < 4; it++) begin
            v = ($urandom_range(0, 9) < 7);
            d = 16'($urandom); c = 16'($urandom); s = 16'($urandom);
            send(v, d, c, s);
            if (v) begin
                si += longint'(d) * longint'(c);
                sq -= longint'(d) * longint'(s);
                n++;
                if (n == DEC) begin
                    model_scale(si, ei, s1);
                    model_scale(sq, eq, s2);
                    ovf_m = ovf_m | s1 | s2;
                    e_cyc.push_back(cyc + 2); e_i.push_back(ei); e_q.push_back(eq);
                    si = 0; sq = 0; n = 0; blocks++;
                end
            end
        end
        idle(4);
        checks++; if (pq_cyc.size() != e_cyc.size()) begin errors++; $display("FAIL rand_pulses: got %0d expected %0d", pq_cyc.size(), e_cyc.size()); end
        else begin
            for (int k = 0; k < e_cyc.size(); k++) begin
                checks++;
                if (pq_cyc[k] != e_cyc[k] || pq_i[k] !== e_i[k] || pq_q[k] !== e_q[k]) begin
                    errors++;
                    $display("FAIL rand_block_%0d: got %0d/%0d at %0d expected %0d/%0d at %0d",
                             k, pq_i[k], pq_q[k], pq_cyc[k], e_i[k], e_q[k], e_cyc[k]);
                end
            end
        end
        checks++; if (ovf !== ovf_m) begin errors++; $display("FAIL rand_ovf: got %0b expected %0b", ovf, ovf_m); end
    endtask

    initial begin
        test_reset();
        test_cos_block();
        test_sin_block();
        test_ovf();
        test_clear();
        test_gaps();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iq_demod.md
IQ_DEMOD -- requirements
Module: IQ_DEMOD

Interface
REQ-001 SHALL have parameter DEC_LEN, default 64, samples per integrate-and-dump block, legal 2..65536.
REQ-002 SHALL have parameter SHIFT, default 6, extra output right-shift, legal 0..16.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port clr, input, 1, synchronous clear of block state.
REQ-006 SHALL have port in_valid, input, 1, input sample strobe.
REQ-007 SHALL have port in_data, input, 16 (`ws16_t`), signed input sample.
REQ-008 SHALL have port cos, input, 16 (`ws16_t`), signed LO from the CORDIC generator, same-cycle aligned with in_data.
REQ-009 SHALL have port sin, input, 16 (`ws16_t`), signed LO from the CORDIC generator, same-cycle aligned with in_data.
REQ-010 SHALL have port out_valid, output, 1, one-cycle result strobe.
REQ-011 SHALL have port i_out, output, 16 (`ws16_t`), signed in-phase result.
REQ-012 SHALL have port q_out, output, 16 (`ws16_t`), signed quadrature result.
REQ-013 SHALL have port ovf, output, 1, sticky saturation flag.

Function
REQ-014 SHALL compute, per accepted sample (in_valid=1), products pi = in_data*cos and pq = -(in_data*sin), each full-precision signed 32-bit, registered in stage 1 with a valid bit.
REQ-015 SHALL accumulate stage-1 products into 48-bit signed accumulators acc_i/acc_q in stage 2; no wrap possible for any legal DEC_LEN.
REQ-016 SHALL count accepted products 0..DEC_LEN-1; on the DEC_LEN-th product, dump sum = acc + product, reload acc with 0, and reset the counter to 0, so consecutive blocks have no dead cycle.
REQ-017 SHALL form i_out/q_out = sum >>> (15+SHIFT) (arithmetic shift, truncation toward minus infinity), saturated to [-32768, 32767].
REQ-018 SHALL set ovf when either channel saturates; ovf holds until rst or clr.
REQ-019 SHALL assert out_valid for exactly one cycle, two clock edges after the edge that samples the DEC_LEN-th in_valid; i_out/q_out SHALL hold their value until the next dump.
REQ-020 SHALL ignore cos/sin/in_data while in_valid=0; gaps in in_valid SHALL NOT alter results.
REQ-021 SHALL, on clr=1, zero acc_i, acc_q, counter, ovf, and the stage-1 valid bit, discarding any in-flight product; clr together with in_valid SHALL drop that sample; i_out/q_out keep their value; out_valid=0 in the cycle after clr.
REQ-022 SHALL accept a new sample every cycle (throughput 1 sample/clk).

Reset
REQ-023 SHALL, while rst=0, asynchronously force out_valid=0, i_out=0, q_out=0, ovf=0, counter=0, accumulators=0, stage-1 valid=0.
REQ-024 SHALL treat reset mid-block as discarding the partial block; the first dump after release SHALL follow DEC_LEN fresh accepted samples.

Structure
REQ-025 SHALL take `ws16_t` from the shared types.v; a `ws32_t` (product) and `ws48_t` (accumulator) type SHALL be added there.
REQ-026 SHALL use one sub-module IQ_SAT, combinational shift-and-saturate 48->16 with overflow output, instantiated once per channel.

Verification
REQ-027 SHALL cover: DEC_LEN=64, SHIFT=6, in_data=16384, cos=32767, sin=0 for 64 cycles -> out_valid one pulse 2 edges after the 64th sample, i_out=16383, q_out=0, ovf=0.
REQ-028 SHALL cover: in_data=16384, cos=0, sin=16384, 64 samples -> i_out=0, q_out=-8192.
REQ-029 SHALL cover: in_data=-32768, cos=-32768, sin=0, 64 samples -> i_out=32767, ovf=1, ovf stays 1 through later non-saturating blocks until clr.
REQ-030 SHALL cover: REQ-027 stimulus with in_valid on alternate cycles -> identical result after 64 accepted samples, 128 cycles.
REQ-031 SHALL cover: rst pulsed low after 30 samples -> outputs 0 immediately; next out_valid only after 64 further samples, with value 16383.
REQ-032 SHALL cover: back-to-back blocks at full rate -> out_valid pulses exactly 64 cycles apart, each i_out=16383.
